bus_burst_master: RTL

Parametrised bus traffic master for exercising slaves on the shared system bus. On a `start` pulse it arbitrates for the bus with `req`/`ack` and presents an address. It then runs a burst of `BURST_LEN` beats in write-only, read-only, or write-then-read-verify mode, and counts read-back mismatches. It succeeds the fixed-burst test master and adds programmable address and pattern, data-phase wait stalls, verify mode, and status outputs.

---
 rtl/bus_pkg.sv | 38 +++
 rtl/burst_beat_counter.sv | 31 +++
 rtl/bus_burst_master.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus burst master: FSM encoding, control-bus bit map,
// operation modes and the burst-length encoding helper.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_SWAIT,
    ST_DATA,
    ST_RELEASE,
    ST_DONE
  } state_t;

  localparam int CTRL_WAIT     = 0;
  localparam int CTRL_WE       = 1;
  localparam int CTRL_BURST_LO = 2;
  localparam int CTRL_BURST_HI = 4;

  localparam logic [1:0] MODE_WR  = 2'b00;
  localparam logic [1:0] MODE_RD  = 2'b01;
  localparam logic [1:0] MODE_VFY = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // Wide enough for a beat index up to 8.
  localparam int IDX_W = 4;

  function automatic logic [2:0] burst_code(input int len);
    case (len)
      1:       burst_code = 3'b000;
      2:       burst_code = 3'b001;
      4:       burst_code = 3'b010;
      8:       burst_code = 3'b011;
      default: burst_code = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// Beat index for one burst pass plus the per-beat data pattern (seed + index,
// wrapping at the bus width).
module burst_beat_counter
  import bus_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [BUS_WIDTH-1:0] pattern_base,
  output logic                 last,
  output logic [BUS_WIDTH-1:0] pattern
);

  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx_q <= '0;
    end else if (en) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign last    = (idx_q == IDX_W'(BURST_LEN - 1));
  assign pattern = pattern_base + BUS_WIDTH'(idx_q);

endmodule

// File: rtl/bus_burst_master.sv
// Burst traffic master: arbitrates for the bus, writes and/or reads back a patterned
// burst, and counts read mismatches. Define BUS_MASTER_TIMEOUT_EN to add a watchdog.
//
//   state      | meaning
//   IDLE       | waiting for start, bus outputs quiet
//   REQ        | requesting the bus until ack
//   ADDR       | one cycle presenting address, burst code and we
//   SWAIT      | waiting for the slave to drop wait
//   DATA       | one beat per non-stalled cycle
//   RELEASE    | one cycle with req low between verify passes
//   DONE       | one-cycle done pulse
module bus_burst_master
  import bus_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int CTRL_WIDTH     = 8,
  parameter int BURST_LEN      = 4,
  parameter int ERR_W          = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [BUS_WIDTH-1:0]  base_addr,
  input  logic [BUS_WIDTH-1:0]  pattern_base,
  input  logic                  ack,
  input  logic [BUS_WIDTH-1:0]  bus_in,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  output logic                  req,
  output logic [BUS_WIDTH-1:0]  bus_out,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_W-1:0]      err_count
`ifdef BUS_MASTER_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] addr_q, pat_q;
  logic                 vfy_q, rd_pass_q;
  logic [ERR_W-1:0]     err_q;
  logic                 wait_s, accept, wd_trip;
  logic                 cnt_clr, cnt_en, beat_last;
  logic [BUS_WIDTH-1:0] beat_data;
  logic                 cmp_miss;
  logic                 unused_ctrl;

  assign wait_s      = ctrl_in[CTRL_WAIT];
  assign unused_ctrl = ^ctrl_in[CTRL_WIDTH-1:1];
  assign accept      = (state_q == ST_IDLE) && start;
  assign cnt_clr     = accept || (state_q == ST_RELEASE);
  assign cnt_en      = (state_q == ST_DATA) && !wait_s;
  assign cmp_miss    = cnt_en && rd_pass_q && (bus_in != beat_data);

  burst_beat_counter #(
    .BUS_WIDTH(BUS_WIDTH),
    .BURST_LEN(BURST_LEN)
  ) u_beat (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_clr),
    .en          (cnt_en),
    .pattern_base(pat_q),
    .last        (beat_last),
    .pattern     (beat_data)
  );

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            wd_run, timeout_q;

  // Counts only consecutive waiting cycles; any progress reloads it.
  assign wd_run  = (state_q == ST_REQ) || (state_q == ST_SWAIT) ||
                   ((state_q == ST_DATA) && wait_s);
  assign wd_trip = wd_run && (wd_q == '0);
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= WD_W'(TIMEOUT_CYCLES - 1);
      timeout_q <= 1'b0;
    end else begin
      if (!wd_run || wd_trip) wd_q <= WD_W'(TIMEOUT_CYCLES - 1);
      else                    wd_q <= wd_q - WD_W'(1);
      if (accept)       timeout_q <= 1'b0;
      else if (wd_trip) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_wd;
  assign wd_trip   = 1'b0;
  assign unused_wd = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      pat_q     <= '0;
      vfy_q     <= 1'b0;
      rd_pass_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q    <= base_addr;
        pat_q     <= pattern_base;
        vfy_q     <= (mode == MODE_VFY);
        rd_pass_q <= (mode == MODE_RD) || (mode == MODE_RSV);
        err_q     <= '0;
      end else begin
        if (state_q == ST_RELEASE) rd_pass_q <= 1'b1;
        if (cmp_miss && (err_q != '1)) err_q <= err_q + ERR_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    busy     = (state_q != ST_IDLE);
    done     = 1'b0;
    bus_out  = '0;
    ctrl_out = '0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ: begin
        req = 1'b1;
        if (wd_trip)  state_d = ST_DONE;
        else if (ack) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        req                                    = 1'b1;
        bus_out                                = addr_q;
        ctrl_out[CTRL_BURST_HI:CTRL_BURST_LO]  = burst_code(BURST_LEN);
        ctrl_out[CTRL_WE]                      = ~rd_pass_q;
        state_d                                = ST_SWAIT;
      end
      ST_SWAIT: begin
        req = 1'b1;
        if (wd_trip)     state_d = ST_DONE;
        else if (!wait_s) state_d = ST_DATA;
      end
      ST_DATA: begin
        req = 1'b1;
        if (!rd_pass_q) bus_out = beat_data;
        if (wd_trip) state_d = ST_DONE;
        else if (!wait_s && beat_last)
          state_d = (vfy_q && !rd_pass_q) ? ST_RELEASE : ST_DONE;
      end
      ST_RELEASE: state_d = ST_REQ;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign err_count = err_q;

endmodule
